ccip_mmio_initiator: RTL and testbench

Drives CCI-P MMIO read and write requests into an AFU's `cp2af_sRxPort.c0` and collects MMIO read responses from `af2cp_sTxPort.c2`. It is the host/FIU end of the MMIO path: simulation benches and on-chip self-test wrappers use it to exercise AFU CSRs without a host. It accepts one command at a time and allows at most one read outstanding. Every read is tagged with an incrementing TID, and each read ends with either matched data or a timeout.

---
 rtl/ccip_mmio_initiator.sv | 234 +++++++++++++++++++++++
 tb/tb_ccip_mmio_initiator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_mmio_initiator.sv
// CCI-P MMIO initiator: issues one MMIO read/write at a time into an AFU's c0 Rx
// channel and collects the matching c2 read response or reports a timeout.

package ccip_if_pkg;
  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [63:0]  t_ccip_mmioData;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [73:0]  t_ccip_c0_ReqMemHdr;
  typedef logic [79:0]  t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic        format;
    logic        rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;
endpackage

module ccip_mmio_initiator
  import ccip_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic        Clk_400,
  input  logic        SoftReset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic        cmd_len8,
  input  logic [63:0] cmd_wdata,
  output t_if_ccip_Rx cp2af_sRxPort,
  input  t_if_ccip_Tx af2cp_sTxPort,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [63:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        rsp_error,
  output logic [15:0] stray_cnt
);

  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t              state, state_next;
  logic                cmd_write_p0, cmd_len8_p0, cmd_err_p0;
  logic [15:0]         tmo_cnt;
  t_ccip_tid           cur_tid;
  logic                accept, misaligned, rd_match, rd_stray, tmo_hit;
  logic [63:0]         rd_data;
  t_ccip_c0_ReqMmioHdr req_hdr;
  t_if_ccip_Rx         rx_next;
  logic                rsp_valid_n, rsp_write_n, rsp_timeout_n, rsp_error_n;
  logic [63:0]         rsp_rdata_n;
  logic                unused_tx;

  assign cmd_ready  = (state == IDLE) & ~SoftReset;
  assign accept     = cmd_valid & cmd_ready;
  assign misaligned = cmd_len8 & cmd_addr[0];

  // A match on the final counter cycle takes priority over the timeout.
  assign rd_match = (state == WAIT_RD) & af2cp_sTxPort.c2.mmioRdValid
                    & (af2cp_sTxPort.c2.hdr.tid == cur_tid);
  assign rd_stray = af2cp_sTxPort.c2.mmioRdValid & ~rd_match;
  assign tmo_hit  = (state == WAIT_RD) & (tmo_cnt == 16'd0) & ~rd_match;
  assign rd_data  = cmd_len8_p0 ? af2cp_sTxPort.c2.data
                                : {32'h0, af2cp_sTxPort.c2.data[31:0]};

  assign unused_tx = ^{af2cp_sTxPort.c0, af2cp_sTxPort.c1};

  always_ff @(posedge Clk_400) begin
    if (SoftReset) state <= IDLE;
    else           state <= state_next;
  end

  // Misaligned commands still spend one cycle in ISSUE (with no valid driven)
  // so that every non-read completion lands two cycles after acceptance.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = (cmd_write_p0 | cmd_err_p0) ? DONE : WAIT_RD;
      WAIT_RD: if (rd_match | tmo_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_hdr       = '0;
    rx_next       = '0;
    rsp_valid_n   = 1'b0;
    rsp_write_n   = 1'b0;
    rsp_error_n   = 1'b0;
    rsp_timeout_n = 1'b0;
    rsp_rdata_n   = '0;
    if (accept && !misaligned) begin
      req_hdr.address         = cmd_addr;
      req_hdr.length          = cmd_len8 ? 2'b01 : 2'b00;
      req_hdr.tid             = cur_tid;
      rx_next.c0.hdr          = t_ccip_c0_RspMemHdr'(req_hdr);
      rx_next.c0.data[63:0]   = cmd_write ? (cmd_len8 ? cmd_wdata : {2{cmd_wdata[31:0]}})
                                          : 64'h0;
      rx_next.c0.mmioWrValid  = cmd_write;
      rx_next.c0.mmioRdValid  = ~cmd_write;
    end
    if (state_next == DONE) begin
      rsp_valid_n   = 1'b1;
      rsp_write_n   = cmd_write_p0;
      rsp_error_n   = cmd_err_p0;
      rsp_timeout_n = tmo_hit;
      if (tmo_hit)       rsp_rdata_n = '1;
      else if (rd_match) rsp_rdata_n = rd_data;
    end
  end

  // Stage p0: command attributes captured at acceptance.
  always_ff @(posedge Clk_400) begin
    if (accept) begin
      cmd_write_p0 <= cmd_write;
      cmd_len8_p0  <= cmd_len8;
      cmd_err_p0   <= misaligned;
    end
  end

  always_ff @(posedge Clk_400) begin
    if (state == ISSUE)
      tmo_cnt <= TMO_LOAD;
    else if (state == WAIT_RD && tmo_cnt != 16'd0)
      tmo_cnt <= tmo_cnt - 16'd1;
  end

  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      cur_tid   <= '0;
      stray_cnt <= '0;
    end else begin
      if (rd_match | tmo_hit)
        cur_tid <= cur_tid + 9'd1;
      if (rd_stray && stray_cnt != 16'hFFFF)
        stray_cnt <= stray_cnt + 16'd1;
    end
  end

  // Stage p1: registered request and completion outputs.
  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      cp2af_sRxPort <= '0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      cp2af_sRxPort <= rx_next;
      rsp_valid     <= rsp_valid_n;
      rsp_write     <= rsp_write_n;
      rsp_error     <= rsp_error_n;
      rsp_timeout   <= rsp_timeout_n;
      rsp_rdata     <= rsp_rdata_n;
    end
  end

endmodule

// File: tb/tb_ccip_mmio_initiator.sv
// Scoreboard bench for ccip_mmio_initiator with a one-cycle registered MMIO
// responder (normal / silent / wrong-TID-first modes).
`timescale 1ns/1ps
module tb_ccip_mmio_initiator;
  import ccip_if_pkg::*;

  localparam int TMO = 8;
  localparam int NORMAL = 0, SILENT = 1, WRONG = 2;
  localparam logic [63:0] DFH = 64'h1000_0100_0000_0000;

  logic        Clk_400 = 1'b0;
  logic        SoftReset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_len8;
  logic [15:0] cmd_addr;
  logic [63:0] cmd_wdata;
  t_if_ccip_Rx cp2af_sRxPort;
  t_if_ccip_Tx af2cp_sTxPort;
  logic        rsp_valid, rsp_write, rsp_timeout, rsp_error;
  logic [63:0] rsp_rdata;
  logic [15:0] stray_cnt;

  always #5 Clk_400 = ~Clk_400;

  ccip_mmio_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .Clk_400(Clk_400), .SoftReset(SoftReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len8(cmd_len8), .cmd_wdata(cmd_wdata),
    .cp2af_sRxPort(cp2af_sRxPort), .af2cp_sTxPort(af2cp_sTxPort),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .rsp_error(rsp_error), .stray_cnt(stray_cnt)
  );

  typedef struct { logic wr; logic to; logic err; logic [63:0] rdata; int cycle; } rsp_exp_t;
  typedef struct { logic wr; logic [15:0] addr; logic [1:0] len; logic [8:0] tid;
                   logic [63:0] data; int cycle; } c0_exp_t;
  typedef struct { logic [8:0] tid; logic [63:0] data; } tx_ent_t;

  rsp_exp_t    rsp_q[$];
  c0_exp_t     c0_q[$];
  tx_ent_t     tx_q[$];
  logic [63:0] mem [logic [15:0]];
  int          resp_mode = NORMAL;
  logic [8:0]  exp_tid;
  int          cyc = 0;
  int          checks = 0, errors = 0;

  always @(posedge Clk_400) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Completion monitor
  initial begin
    rsp_exp_t re;
    forever begin
      @(negedge Clk_400);
      if (rsp_valid === 1'b1) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid at cycle %0d required none", cyc + 1);
        end else begin
          re = rsp_q.pop_front();
          check64("rsp_cycle", 64'(cyc + 1), 64'(re.cycle));
          check64("rsp_write", 64'(rsp_write), 64'(re.wr));
          check64("rsp_timeout", 64'(rsp_timeout), 64'(re.to));
          check64("rsp_error", 64'(rsp_error), 64'(re.err));
          if (!re.wr && !re.err) check64("rsp_rdata", rsp_rdata, re.rdata);
        end
      end
    end
  end

  // Request-wire monitor
  initial begin
    c0_exp_t ce;
    t_ccip_c0_ReqMmioHdr h;
    forever begin
      @(negedge Clk_400);
      if (cp2af_sRxPort.c0.mmioRdValid === 1'b1 || cp2af_sRxPort.c0.mmioWrValid === 1'b1) begin
        if (c0_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL c0_unexpected: got c0 valid at cycle %0d required none", cyc + 1);
        end else begin
          ce = c0_q.pop_front();
          h  = t_ccip_c0_ReqMmioHdr'(cp2af_sRxPort.c0.hdr);
          check64("c0_cycle", 64'(cyc + 1), 64'(ce.cycle));
          check64("c0_wrvalid", 64'(cp2af_sRxPort.c0.mmioWrValid), 64'(ce.wr));
          check64("c0_rdvalid", 64'(cp2af_sRxPort.c0.mmioRdValid), 64'(!ce.wr));
          check64("c0_addr", 64'(h.address), 64'(ce.addr));
          check64("c0_len", 64'(h.length), 64'(ce.len));
          check64("c0_tid", 64'(h.tid), 64'(ce.tid));
          if (ce.wr) check64("c0_wdata", cp2af_sRxPort.c0.data[63:0], ce.data);
        end
      end
    end
  end

  // One-cycle registered responder
  initial begin
    tx_ent_t t;
    t_ccip_c0_ReqMmioHdr h;
    logic [63:0] rd;
    af2cp_sTxPort = '0;
    forever begin
      @(posedge Clk_400); #1;
      af2cp_sTxPort = '0;
      if (tx_q.size() > 0) begin
        t = tx_q.pop_front();
        af2cp_sTxPort.c2.mmioRdValid = 1'b1;
        af2cp_sTxPort.c2.hdr.tid     = t.tid;
        af2cp_sTxPort.c2.data        = t.data;
      end
      h = t_ccip_c0_ReqMmioHdr'(cp2af_sRxPort.c0.hdr);
      if (cp2af_sRxPort.c0.mmioWrValid) mem[h.address] = cp2af_sRxPort.c0.data[63:0];
      if (cp2af_sRxPort.c0.mmioRdValid) begin
        rd = (h.address == 16'h0) ? DFH : (mem.exists(h.address) ? mem[h.address] : 64'h0);
        if (resp_mode == WRONG) begin
          tx_q.push_back('{tid: h.tid + 9'd5, data: 64'hBAD0_BAD0_BAD0_BAD0});
          tx_q.push_back('{tid: h.tid, data: rd});
        end else if (resp_mode == NORMAL) begin
          tx_q.push_back('{tid: h.tid, data: rd});
        end
      end
    end
  end

  // Called at a negedge; expectations are queued before the accepting edge.
  task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic len8,
                         input logic [63:0] wdata, input bit exp_c0, input int lat,
                         input bit exp_rsp, input logic to, input logic err,
                         input logic [63:0] rdata);
    int n = 0;
    bit got = 0;
    int acc;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len8 = len8; cmd_wdata = wdata;
    while (!got && n < 100) begin
      if (cmd_ready === 1'b1) begin
        got = 1;
        acc = cyc + 1;
        if (exp_c0)
          c0_q.push_back('{wr: wr, addr: addr, len: len8 ? 2'b01 : 2'b00, tid: exp_tid,
                           data: len8 ? wdata : {wdata[31:0], wdata[31:0]}, cycle: acc + 1});
        if (exp_rsp)
          rsp_q.push_back('{wr: wr, to: to, err: err, rdata: rdata, cycle: acc + lat});
        if (exp_c0 && !wr) exp_tid = exp_tid + 9'd1;
      end else begin
        @(negedge Clk_400);
        n++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got cmd_ready=0 for 100 cycles required 1");
    end
    @(negedge Clk_400);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rsp_q.size() != 0 || c0_q.size() != 0 || tx_q.size() != 0) && n < 60) begin
      @(negedge Clk_400);
      n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL drain: got %0d rsp pending required 0", rsp_q.size());
    end
  endtask

  task automatic check_reset_outputs();
    check64("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check64("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check64("rst_rsp_flags", 64'({rsp_write, rsp_timeout, rsp_error}), 64'd0);
    check64("rst_rsp_rdata", rsp_rdata, 64'd0);
    check64("rst_rx_zero", 64'(cp2af_sRxPort == '0), 64'd1);
    check64("rst_stray", 64'(stray_cnt), 64'd0);
  endtask

  initial begin
    SoftReset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_len8 = 1'b0; cmd_wdata = '0; exp_tid = '0;
    repeat (3) @(negedge Clk_400);
    check_reset_outputs();
    SoftReset = 1'b0;
    @(negedge Clk_400);
    check64("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // DFH read, then 8-byte write and readback
    run_cmd(1'b0, 16'h0000, 1'b1, 64'h0, 1, 3, 1, 1'b0, 1'b0, DFH);
    wait_drain();
    run_cmd(1'b1, 16'h0020, 1'b1, 64'hDEAD_BEEF_0123_4567, 1, 2, 1, 1'b0, 1'b0, 64'h0);
    wait_drain();
    run_cmd(1'b0, 16'h0020, 1'b1, 64'h0, 1, 3, 1, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567);
    wait_drain();

    // 4-byte write replicates the low word; 4-byte read zero-extends
    run_cmd(1'b1, 16'h0030, 1'b0, 64'h1111_2222_A5A5_5A5A, 1, 2, 1, 1'b0, 1'b0, 64'h0);
    wait_drain();
    run_cmd(1'b0, 16'h0030, 1'b0, 64'h0, 1, 3, 1, 1'b0, 1'b0, 64'h0000_0000_A5A5_5A5A);
    wait_drain();

    // Wrong TID first, then the right one
    resp_mode = WRONG;
    run_cmd(1'b0, 16'h0020, 1'b1, 64'h0, 1, 4, 1, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567);
    wait_drain();
    check64("stray_wrong_tid", 64'(stray_cnt), 64'd1);

    // Timeout (TID 4), then the late response for TID 4 is a stray
    resp_mode = SILENT;
    run_cmd(1'b0, 16'h0020, 1'b1, 64'h0, 1, TMO + 2, 1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_drain();
    tx_q.push_back('{tid: 9'd4, data: 64'h1234});
    repeat (3) @(negedge Clk_400);
    check64("stray_late", 64'(stray_cnt), 64'd2);
    resp_mode = NORMAL;
    run_cmd(1'b0, 16'h0000, 1'b1, 64'h0, 1, 3, 1, 1'b0, 1'b0, DFH);
    wait_drain();

    // Misaligned 8-byte read and write; odd 4-byte read is legal
    run_cmd(1'b0, 16'h0003, 1'b1, 64'h0, 0, 2, 1, 1'b0, 1'b1, 64'h0);
    wait_drain();
    run_cmd(1'b1, 16'h0005, 1'b1, 64'h55, 0, 2, 1, 1'b0, 1'b1, 64'h0);
    wait_drain();
    run_cmd(1'b0, 16'h0003, 1'b0, 64'h0, 1, 3, 1, 1'b0, 1'b0, 64'h0);
    wait_drain();

    // Reset while a read (TID 7) is outstanding
    resp_mode = SILENT;
    run_cmd(1'b0, 16'h0000, 1'b1, 64'h0, 1, 0, 0, 1'b0, 1'b0, 64'h0);
    repeat (3) @(negedge Clk_400);
    SoftReset = 1'b1;
    @(negedge Clk_400);
    check_reset_outputs();
    SoftReset = 1'b0;
    exp_tid = '0;
    resp_mode = NORMAL;
    tx_q.push_back('{tid: 9'd7, data: 64'h77});
    repeat (3) @(negedge Clk_400);
    check64("stray_after_reset", 64'(stray_cnt), 64'd1);

    // 513 reads: TID runs 0..511 then wraps to 0
    for (int i = 0; i < 513; i++) begin
      run_cmd(1'b0, 16'h0000, 1'b1, 64'h0, 1, 3, 1, 1'b0, 1'b0, DFH);
      wait_drain();
    end
    check64("stray_final", 64'(stray_cnt), 64'd1);
    check64("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    check64("c0_q_empty", 64'(c0_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1ms required finish");
    $fatal(1, "watchdog");
  end

endmodule
